// File: rtl/zap_wb_ram_responder.sv
// Wishbone B3 responder backed by a word-addressed RAM. Serves classic cycles and
// linear incrementing bursts with programmable wait states; out-of-range beats return err.
module zap_wb_ram_responder #(
   parameter int unsigned DEPTH       = 32'd4096,
   parameter int unsigned WAIT_STATES = 32'd0
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [31:0] i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   input  logic [2:0]  i_wb_cti,
   input  logic [1:0]  i_wb_bte,
   output logic        o_wb_ack,
   output logic        o_wb_err,
   output logic [31:0] o_wb_dat
);

   localparam int unsigned AddrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  WaitCnt = 4'(WAIT_STATES);
   localparam logic [2:0]  CtiIncr = 3'b010;

   typedef enum logic [1:0] {StIdle, StWait, StBeat, StGap} state_e;

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [29:0]      ptr_q, ptr_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic [31:0]      dat_q, dat_d;
   logic [31:0]      mem [DEPTH];
   logic [AddrW-1:0] idx;
   logic             in_range;
   logic             bad_burst;
   logic             fault;
   logic             beat;
   logic             mem_we;
   logic             unused_adr;

   assign idx        = ptr_q[AddrW-1:0];
   assign in_range   = ({2'b00, ptr_q} < DEPTH);
   assign bad_burst  = (i_wb_cti == CtiIncr) && (i_wb_bte != 2'b00);
   assign fault      = !in_range || bad_burst;
   // A beat only completes while the master strobes; stb=0 inside a cycle is a hold.
   assign beat       = (state_q == StBeat) && i_wb_cyc && i_wb_stb;
   assign unused_adr = ^i_wb_adr[1:0];

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         ptr_q   <= 30'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      if (!i_wb_cyc) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (i_wb_stb) begin
                  ptr_d   = i_wb_adr[31:2];
                  cnt_d   = WaitCnt;
                  state_d = (WAIT_STATES > 0) ? StWait : StBeat;
               end
            end
            StWait: begin
               if (i_wb_stb) begin
                  cnt_d = cnt_q - 4'd1;
                  if (cnt_q <= 4'd1) begin
                     state_d = StBeat;
                  end
               end
            end
            StBeat: begin
               if (i_wb_stb) begin
                  if (i_wb_cti == CtiIncr) begin
                     ptr_d = ptr_q + 30'd1;
                     if (WAIT_STATES > 0) begin
                        cnt_d   = WaitCnt;
                        state_d = StWait;
                     end
                  end else begin
                     state_d = StGap;
                  end
               end
            end
            StGap: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_comb begin
      ack_d  = beat && !fault;
      err_d  = beat && fault;
      dat_d  = dat_q;
      mem_we = 1'b0;
      if (beat && !fault) begin
         if (i_wb_we) begin
            // Gate with reset so a write coinciding with reset assertion is dropped.
            mem_we = i_reset_n;
         end else begin
            dat_d = mem[idx];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (i_wb_sel[i]) begin
               mem[idx][8*i +: 8] <= i_wb_dat[8*i +: 8];
            end
         end
      end
   end

   assign o_wb_ack = ack_q;
   assign o_wb_err = err_q;
   assign o_wb_dat = dat_q;

endmodule
